// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared FSM state type, block sizing constants and counter width helper
package aes_uart_pkg;
    localparam int DEFAULT_N = 128;
    localparam int BYTES_PER_BLOCK = DEFAULT_N / 8;
    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_IDLE, START, WAIT_BUSY, WAIT_DONE, GAP, FINISH
    } tx_state_t;
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction
endpackage

// File: rtl/aes_tx_cycle_timer.sv
// aes_tx_cycle_timer: loadable down-counter that parks at zero and flags expiry
// Ports: clk, reset (async, active high), load/load_value (restart count), expired (count is zero)
module aes_tx_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);
    logic [W-1:0] count;
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (load) count <= load_value;
        else if (count != '0) count <= count - W'(1);
    assign expired = count == '0;
endmodule

// File: rtl/aes_block_tx_serializer.sv
// aes_block_tx_serializer: sends an N-bit block to a byte UART transmitter, byte 0 first
// Ports: clk, reset (async, active high)
//   blk_data/blk_valid/blk_ready: block input handshake
//   uart_tx_ready/uart_tx_start/uart_transmit_data: byte handshake to the UART transmitter
//   busy: block in flight; block_done: one-cycle pulse after last byte; tx_timeout: sticky handshake timeout
module aes_block_tx_serializer
    import aes_uart_pkg::*;
#(
    parameter int N              = DEFAULT_N,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] blk_data,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         uart_tx_ready,
    output logic         uart_tx_start,
    output logic [7:0]   uart_transmit_data,
    output logic         busy,
    output logic         block_done,
    output logic         tx_timeout
);
    localparam int NB = N / 8;
    localparam int IW = $clog2(NB) + 1;
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    // GAP is left when the timer reaches zero, so loading G-1 yields exactly G cycles
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES);
    tx_state_t state, next;
    logic [N-1:0] shreg;
    logic [IW-1:0] idx;
    logic gap_exp, to_exp, accept, in_wait, enter_wait, last;
    assign blk_ready = (state == IDLE) && !reset;
    assign accept = blk_valid && blk_ready;
    assign busy = state != IDLE;
    assign block_done = state == FINISH;
    assign in_wait = state inside {WAIT_IDLE, WAIT_BUSY, WAIT_DONE};
    assign enter_wait = (next inside {WAIT_IDLE, WAIT_BUSY, WAIT_DONE}) && next != state;
    assign last = idx == IW'(NB - 1);
    // start drops combinationally as soon as the UART goes busy or the handshake times out
    assign uart_tx_start = (state == START) || (state == WAIT_BUSY && uart_tx_ready && !to_exp);
    always_comb begin
        next = state;
        case (state)
            IDLE:      if (blk_valid) next = LOAD;
            LOAD:      next = WAIT_IDLE;
            WAIT_IDLE: next = uart_tx_ready ? START : (to_exp ? IDLE : WAIT_IDLE);
            START:     next = WAIT_BUSY;
            WAIT_BUSY: next = !uart_tx_ready ? WAIT_DONE : (to_exp ? IDLE : WAIT_BUSY);
            WAIT_DONE: next = uart_tx_ready ? (last ? FINISH : (GAP_CYCLES == 0 ? LOAD : GAP))
                                            : (to_exp ? IDLE : WAIT_DONE);
            GAP:       if (gap_exp) next = LOAD;
            FINISH:    next = IDLE;
            default:   next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            idx <= '0;
            uart_transmit_data <= 8'h00;
            tx_timeout <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                shreg <= blk_data;
                idx <= '0;
                tx_timeout <= 1'b0;
            end
            if (state == LOAD) uart_transmit_data <= 8'(shreg >> {idx, 3'b000});
            if (state == WAIT_DONE && uart_tx_ready) idx <= idx + IW'(1);
            if (in_wait && next == IDLE) tx_timeout <= 1'b1;
        end
    aes_tx_cycle_timer #(.W(GW)) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (next == GAP && state != GAP),
        .load_value (GAP_LOAD),
        .expired    (gap_exp)
    );
    aes_tx_cycle_timer #(.W(TW)) u_timeout_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (enter_wait),
        .load_value (TO_LOAD),
        .expired    (to_exp)
    );
endmodule

// File: tb/tb_aes_block_tx_serializer.sv
// tb_aes_block_tx_serializer: directed bench for the block serializer with simple UART models
module tb_aes_block_tx_serializer;
    import aes_uart_pkg::*;
    localparam int TO = 50;
    localparam int GAPA = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int tests = 0;
    int fails = 0;
    logic [127:0] a_data = '0, b_data = '0;
    logic a_valid = 1'b0, b_valid = 1'b0, a_hold = 1'b0;
    logic a_ready, a_start, a_busy, a_done, a_to, b_ready, b_start, b_busy, b_done, b_to;
    logic [7:0] a_tx, b_tx;
    logic a_mrdy = 1'b1, b_mrdy = 1'b1, a_prev = 1'b1;
    logic a_urdy;
    assign a_urdy = a_mrdy & ~a_hold;
    int a_cnt = 0, b_cnt = 0, a_n = 0, b_n = 0, a_dn = 0, b_dn = 0, a_rise = 0, a_gi = 0;
    logic [7:0] a_bytes [0:127];
    logic [7:0] b_bytes [0:127];
    int a_gap [0:127];

    aes_block_tx_serializer #(.N(128), .GAP_CYCLES(GAPA), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk(clk), .reset(reset), .blk_data(a_data), .blk_valid(a_valid), .blk_ready(a_ready),
        .uart_tx_ready(a_urdy), .uart_tx_start(a_start), .uart_transmit_data(a_tx),
        .busy(a_busy), .block_done(a_done), .tx_timeout(a_to)
    );
    aes_block_tx_serializer #(.N(128), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk(clk), .reset(reset), .blk_data(b_data), .blk_valid(b_valid), .blk_ready(b_ready),
        .uart_tx_ready(b_mrdy), .uart_tx_start(b_start), .uart_transmit_data(b_tx),
        .busy(b_busy), .block_done(b_done), .tx_timeout(b_to)
    );

    // UART models: accept a byte on start while idle, then stay busy for 10 cycles
    always @(posedge clk) begin
        if (a_cnt != 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) a_mrdy <= 1'b1;
        end else if (a_urdy && a_start) begin
            a_mrdy <= 1'b0;
            a_cnt <= 10;
            a_bytes[7'(a_n)] <= a_tx;
            a_n <= a_n + 1;
        end
    end
    always @(posedge clk) begin
        if (b_cnt != 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) b_mrdy <= 1'b1;
        end else if (b_mrdy && b_start) begin
            b_mrdy <= 1'b0;
            b_cnt <= 10;
            b_bytes[7'(b_n)] <= b_tx;
            b_n <= b_n + 1;
        end
    end
    // records done pulses and cycles from UART ready rising to the next start
    always @(negedge clk) begin
        a_prev <= a_urdy;
        if (a_urdy && !a_prev) a_rise <= cyc;
        if (a_start) begin
            a_gap[7'(a_gi)] <= cyc - a_rise;
            a_gi <= a_gi + 1;
        end
        if (a_done) a_dn <= a_dn + 1;
        if (b_done) b_dn <= b_dn + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [127:0] d, output int hc);
        int n = 0;
        @(negedge clk);
        a_data = d;
        a_valid = 1'b1;
        while (!a_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        hc = cyc;
        check("a_accept_ready", a_ready, 1'b1);
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, input int target);
        int n = 0;
        while ((sel_b ? b_dn : a_dn) < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(sel_b ? "b_done_wait" : "a_done_wait", sel_b ? b_dn : a_dn, target);
    endtask

    initial begin
        int hc, base, gb, n, dn0;
        logic [127:0] r_blk, d_blk, x_blk, y_blk;
        r_blk = 128'h112233445566778899AABBCCDDEEFF01;
        d_blk = 128'hA55A3CC30FF0123456789ABCDEF00102;
        x_blk = 128'h0F0E0D0C0B0A09080706050403020100;
        y_blk = 128'h1F1E1D1C1B1A19181716151413121110;
        #1 reset = 1'b1;
        #1;
        check("rst_blk_ready", a_ready, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_start", a_start, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_timeout", a_to, 1'b0);
        check("rst_data", a_tx, 8'h00);
        check("rst_b_timeout", b_to, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_blk_ready", a_ready, 1'b1);

        // block 1: latency, byte order, gap spacing, single done pulse
        base = a_n;
        gb = a_gi;
        dn0 = a_dn;
        send_a(128'h000102030405060708090A0B0C0D0E0F, hc);
        n = 0;
        while (!a_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("first_start_latency", cyc - hc, 3);
        wait_done(1'b0, dn0 + 1);
        check("blk1_byte_count", a_n - base, BYTES_PER_BLOCK);
        for (int k = 0; k < BYTES_PER_BLOCK; k++)
            check($sformatf("blk1_byte%0d", k), a_bytes[7'(base + k)], 8'(15 - k));
        for (int k = 1; k < BYTES_PER_BLOCK; k++)
            check($sformatf("blk1_gap%0d", k), a_gap[7'(gb + k)], GAPA + 3);
        repeat (5) @(negedge clk);
        check("blk1_one_done", a_dn - dn0, 1);
        check("blk1_idle_ready", a_ready, 1'b1);

        // timeout while waiting for the UART to be idle
        a_hold = 1'b1;
        dn0 = a_dn;
        send_a(128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, hc);
        while (cyc < hc + TO + 2) @(negedge clk);
        check("to_not_yet", a_to, 1'b0);
        check("to_busy_before", a_busy, 1'b1);
        @(negedge clk);
        check("to_flag", a_to, 1'b1);
        check("to_idle_ready", a_ready, 1'b1);
        check("to_busy_after", a_busy, 1'b0);
        check("to_start_low", a_start, 1'b0);
        a_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("to_sticky", a_to, 1'b1);
        check("to_no_done", a_dn - dn0, 0);

        // reset during byte 7 completion wait
        base = a_n;
        dn0 = a_dn;
        send_a(r_blk, hc);
        @(negedge clk);
        check("to_clear_on_accept", a_to, 1'b0);
        n = 0;
        while (a_n < base + 8 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("mid_data_before_reset", a_tx, r_blk[63:56]);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_start", a_start, 1'b0);
        check("mid_rst_busy", a_busy, 1'b0);
        check("mid_rst_ready", a_ready, 1'b0);
        check("mid_rst_done", a_done, 1'b0);
        check("mid_rst_data", a_tx, 8'h00);
        check("mid_rst_bytes", a_n - base, 8);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++)
            check($sformatf("rst_blk_byte%0d", k), a_bytes[7'(base + k)], r_blk[8*k +: 8]);
        check("rst_no_done", a_dn - dn0, 0);

        // new block after reset; input disturbed while busy
        base = a_n;
        dn0 = a_dn;
        send_a(d_blk, hc);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            a_valid = i[0];
            a_data = {4{$urandom}};
        end
        a_valid = 1'b0;
        wait_done(1'b0, dn0 + 1);
        check("d_byte_count", a_n - base, BYTES_PER_BLOCK);
        check("d_restart_byte0", a_bytes[7'(base)], 8'h02);
        for (int k = 0; k < BYTES_PER_BLOCK; k++)
            check($sformatf("d_byte%0d", k), a_bytes[7'(base + k)], d_blk[8*k +: 8]);
        repeat (5) @(negedge clk);
        check("d_one_done", a_dn - dn0, 1);

        // back-to-back blocks with no inter-byte gap
        base = b_n;
        dn0 = b_dn;
        @(negedge clk);
        b_data = x_blk;
        b_valid = 1'b1;
        check("b_idle_ready", b_ready, 1'b1);
        @(posedge clk);
        #1 b_data = y_blk;
        n = 0;
        @(negedge clk);
        while (!b_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready_seen", b_ready, 1'b1);
        check("b2b_first_done", b_dn - dn0, 1);
        @(posedge clk);
        #1 b_valid = 1'b0;
        @(negedge clk);
        check("b2b_ready_one_cycle", b_ready, 1'b0);
        check("b2b_busy_again", b_busy, 1'b1);
        wait_done(1'b1, dn0 + 2);
        check("b2b_byte_count", b_n - base, 2 * BYTES_PER_BLOCK);
        for (int k = 0; k < 2 * BYTES_PER_BLOCK; k++)
            check($sformatf("b2b_byte%0d", k), b_bytes[7'(base + k)], 8'(k));
        repeat (5) @(negedge clk);
        check("b2b_two_done", b_dn - dn0, 2);
        check("b2b_no_timeout", b_to, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_block_tx_serializer.md
AES_BLOCK_TX_SERIALIZER -- requirements
Module: aes_block_tx_serializer

Interface
REQ-001 Parameter N, default 128, block width in bits; SHALL be a multiple of 8.
REQ-002 Parameter GAP_CYCLES, default 1000, idle clocks inserted between consecutive bytes.
REQ-003 Parameter TIMEOUT_CYCLES, default 4095, max clocks allowed per UART handshake phase.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 blk_data  input  N  ciphertext block; byte k is bits [8k+7:8k].
REQ-007 blk_valid  input  1  blk_data is valid.
REQ-008 blk_ready  output  1  serializer can accept a block.
REQ-009 uart_tx_ready  input  1  UART transmitter is idle; low while a byte is shifting.
REQ-010 uart_tx_start  output  1  byte request to the UART transmitter.
REQ-011 uart_transmit_data  output  8  byte being sent.
REQ-012 busy  output  1  a block is in flight.
REQ-013 block_done  output  1  one-cycle pulse after the last byte completes.
REQ-014 tx_timeout  output  1  sticky error flag for a UART handshake timeout.

Function
REQ-015 States SHALL be IDLE, LOAD, WAIT_IDLE, START, WAIT_BUSY, WAIT_DONE, GAP, FINISH.
REQ-016 blk_ready SHALL equal (state==IDLE) AND NOT reset.
REQ-017 When blk_valid and blk_ready are both high, blk_data SHALL be captured into an internal N-bit register, the byte index SHALL be cleared, and the FSM SHALL go to LOAD.
REQ-018 LOAD: uart_transmit_data SHALL take byte[index]; the FSM SHALL then go to WAIT_IDLE.
REQ-019 WAIT_IDLE: the FSM SHALL go to START when uart_tx_ready is high, else hold.
REQ-020 START and WAIT_BUSY: uart_tx_start SHALL be high.
  - The FSM SHALL go to WAIT_BUSY the next cycle.
  - It SHALL leave WAIT_BUSY when uart_tx_ready falls; uart_tx_start SHALL drop that same cycle.
REQ-021 WAIT_DONE: on uart_tx_ready rising, the index SHALL increment.
  - If the completed byte was byte N/8-1, the FSM SHALL go to FINISH.
  - Otherwise it SHALL go to GAP.
REQ-022 GAP SHALL last exactly GAP_CYCLES clocks, then go to LOAD; GAP_CYCLES=0 SHALL go straight to LOAD.
REQ-023 FINISH SHALL pulse block_done for one cycle, then return to IDLE.
REQ-024 First-byte latency: uart_tx_start SHALL rise 3 cycles after the accepting edge when uart_tx_ready is already high.
REQ-025 Bytes SHALL be sent in LSB-first order: byte 0 first, byte N/8-1 last.
REQ-026 uart_transmit_data SHALL be held stable from LOAD until WAIT_DONE exits.
REQ-027 A single timeout counter SHALL clear on every entry to WAIT_IDLE, WAIT_BUSY or WAIT_DONE. If any of these states exceeds TIMEOUT_CYCLES:
  - tx_timeout SHALL set;
  - uart_tx_start SHALL drop;
  - the block SHALL be abandoned and the FSM SHALL go to IDLE with no block_done.
REQ-028 tx_timeout SHALL clear only on reset or on the next block acceptance.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 blk_valid SHALL be ignored outside IDLE, and blk_data changes after capture SHALL have no effect.
REQ-031 Counter widths SHALL be $clog2(param+1); the index width SHALL be $clog2(N/8)+1, so the index holds N/8 without wrap.
REQ-032 The timeout counter SHALL saturate and SHALL NOT wrap.

Reset
REQ-033 While reset is high, the block SHALL hold:
  - state IDLE, index 0, all counters 0;
  - shift register 0, uart_transmit_data 8'h00;
  - uart_tx_start, busy, block_done, tx_timeout and blk_ready all 0.
REQ-034 Reset asserted mid-block SHALL immediately drop uart_tx_start and discard the block, with no block_done pulse.

Structure
REQ-035 The state enum and the BYTES_PER_BLOCK = N/8 constant SHALL reside in shared package aes_uart_pkg.
REQ-036 The down-counter used for GAP and timeout timing SHALL be sub-module aes_tx_cycle_timer, with ports clk, reset, load, load_value, expired.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
  - Block 128'h000102...0F accepted, UART model 10-cycle busy, GAP_CYCLES=4: bytes 0x0F,0x0E,...,0x00 sent, i.e. byte 0 (0x0F) first and byte 15 (0x00) last; exactly 4 idle cycles between busy ends and the next start; one block_done.
  - uart_tx_ready held high at acceptance: uart_tx_start rises exactly 3 cycles after the handshake edge.
  - uart_tx_ready held low for TIMEOUT_CYCLES+1 in WAIT_IDLE: tx_timeout=1, FSM back in IDLE, blk_ready=1, no block_done.
  - reset pulsed during byte 7's WAIT_DONE: all outputs reach reset values asynchronously; the next block starts at byte 0.
  - blk_valid toggled and blk_data changed while busy: transmitted bytes match the originally captured block.
  - Two back-to-back blocks with GAP_CYCLES=0: 32 bytes in order, two block_done pulses, blk_ready high exactly one cycle between blocks.
